// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared constants for the HD44780-style LCD bus decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // Command prefixes: the position of the highest set bit selects the command
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;
    localparam logic [7:0] CMD_ENTRY = 8'h04;
    localparam logic [7:0] CMD_DISP  = 8'h08;
    localparam logic [7:0] CMD_SHIFT = 8'h10;
    localparam logic [7:0] CMD_FUNC  = 8'h20;
    localparam logic [7:0] CMD_CGRAM = 8'h40;
    localparam logic [7:0] CMD_DDRAM = 8'h80;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HIGH  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE_END   = 7'h27;
    localparam logic [6:0] LINE2_END  = 7'h67;

    // Reduce a command byte to its prefix; 0x00 maps to 0x00 (no-op)
    function automatic logic [7:0] cmd_decode(input logic [7:0] d);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) r = 8'h01 << i;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_ddram_map.sv
`default_nettype none
// ============================================================================
// Module      : lcd_ddram_map
// Description : DDRAM address to shadow-image cell mapping and address stepping.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_ddram_map
    import lcd_pkg::*;
#(
    parameter int CELLS_PER_LINE = 16
) (
    input  logic [6:0] addr,
    input  logic       inc,
    output logic       cell_valid,
    output logic [4:0] cell_idx,
    output logic [6:0] next_addr
);

    logic [6:0] w_line2_off;

    always_comb begin
        w_line2_off = addr - LINE2_BASE;
        cell_valid  = 1'b0;
        cell_idx    = '0;
        if (addr < 7'(CELLS_PER_LINE)) begin
            cell_valid = 1'b1;
            cell_idx   = addr[4:0];
        end else if (addr >= LINE2_BASE && w_line2_off < 7'(CELLS_PER_LINE)) begin
            cell_valid = 1'b1;
            cell_idx   = 5'(CELLS_PER_LINE) + w_line2_off[4:0];
        end
    end

    // The counter skips the gap between the end of line 1 and the start of line 2
    always_comb begin
        next_addr = addr;
        if (inc) begin
            if (addr == LINE_END)       next_addr = LINE2_BASE;
            else if (addr == LINE2_END) next_addr = '0;
            else                        next_addr = addr + 7'd1;
        end else begin
            if (addr == LINE2_BASE)     next_addr = LINE_END;
            else if (addr == 7'd0)      next_addr = LINE2_END;
            else                        next_addr = addr - 7'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_decoder
// Description : Receives HD44780-style LCD writes and keeps a shadow image.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_decoder
    import lcd_pkg::*;
#(
    parameter int         CELLS_PER_LINE = 16,
    parameter int         MIN_EN_HIGH    = 4,
    parameter logic [7:0] CLEAR_CHAR     = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rw,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic [4:0] rd_idx,
    output logic [7:0] rd_char,
    output logic [7:0] dout,
    output logic       dout_oe,
    output logic       busy,
    output logic [6:0] addr,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_mode,
    output logic       two_line,
    output logic       cmd_stb,
    output logic       chr_stb,
    output logic       ovr_err
);

    localparam int              c_ncells  = 2 * CELLS_PER_LINE;
    localparam int              c_cnt_w   = $clog2(MIN_EN_HIGH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = {c_cnt_w{1'b1}};
    localparam logic [4:0]      c_last    = 5'(c_ncells - 1);

    logic [1:0]         r_state, w_next_state;
    logic [c_cnt_w-1:0] r_hi_cnt;
    logic               r_rs, r_rw;
    logic [7:0]         r_data;
    logic [6:0]         r_addr;
    logic               r_disp_on, r_cursor_on, r_blink_on, r_inc_mode, r_two_line;
    logic               r_ovr_err;
    logic [4:0]         r_clr_idx;
    logic [7:0]         r_image [c_ncells];
    logic [7:0]         r_rd_char;

    logic               w_qual_fall, w_exec, w_wr_exec, w_step_inc;
    logic [7:0]         w_cmd;
    logic               w_cell_valid;
    logic [4:0]         w_cell_idx;
    logic [6:0]         w_step_addr;

    // The pulse qualifier runs in every state so pulses ending mid-clear are still seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi_cnt <= '0;
            r_rs     <= 1'b0;
            r_rw     <= 1'b0;
            r_data   <= 8'h00;
        end else if (en) begin
            if (r_hi_cnt != c_cnt_max) r_hi_cnt <= r_hi_cnt + c_cnt_w'(1);
            r_rs   <= rs;
            r_rw   <= rw;
            r_data <= data;
        end else begin
            r_hi_cnt <= '0;
        end
    end

    assign w_qual_fall = !en && (r_hi_cnt >= c_cnt_w'(MIN_EN_HIGH));
    assign w_exec      = w_qual_fall && (r_state == ST_IDLE || r_state == ST_HIGH);
    assign w_wr_exec   = w_exec && !r_rw;
    assign w_cmd       = cmd_decode(r_data);
    assign w_step_inc  = r_rs ? r_inc_mode : r_data[2];

    lcd_ddram_map #(
        .CELLS_PER_LINE (CELLS_PER_LINE)
    ) u_map (
        .addr       (r_addr),
        .inc        (w_step_inc),
        .cell_valid (w_cell_valid),
        .cell_idx   (w_cell_idx),
        .next_addr  (w_step_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_exec) w_next_state = ST_EXEC;
                      else if (en) w_next_state = ST_HIGH;
            ST_HIGH:  if (w_exec) w_next_state = ST_EXEC;
                      else if (!en) w_next_state = ST_IDLE;
            ST_EXEC:  if (!r_rw && !r_rs && w_cmd == CMD_CLEAR) w_next_state = ST_CLEAR;
                      else w_next_state = ST_IDLE;
            ST_CLEAR: if (r_clr_idx == c_last) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Transactions take effect on the edge that leaves HIGH, so EXEC shows the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_disp_on   <= 1'b0;
            r_cursor_on <= 1'b0;
            r_blink_on  <= 1'b0;
            r_inc_mode  <= 1'b1;
            r_two_line  <= 1'b0;
            r_ovr_err   <= 1'b0;
            r_clr_idx   <= '0;
            for (int i = 0; i < c_ncells; i++) r_image[i] <= CLEAR_CHAR;
        end else begin
            if (w_wr_exec) begin
                if (r_rs) begin
                    if (w_cell_valid) r_image[w_cell_idx] <= r_data;
                    r_addr <= w_step_addr;
                end else begin
                    case (w_cmd)
                        CMD_DDRAM: r_addr <= r_data[6:0];
                        CMD_FUNC:  r_two_line <= r_data[3];
                        CMD_SHIFT: if (!r_data[3]) r_addr <= w_step_addr;
                        CMD_DISP:  {r_disp_on, r_cursor_on, r_blink_on} <= r_data[2:0];
                        CMD_ENTRY: r_inc_mode <= r_data[1];
                        CMD_HOME:  r_addr <= '0;
                        default:   ;
                    endcase
                end
            end
            if (r_state == ST_CLEAR) begin
                r_image[r_clr_idx] <= CLEAR_CHAR;
                r_clr_idx          <= r_clr_idx + 5'd1;
                if (r_clr_idx == c_last) r_addr <= '0;
                if (w_qual_fall && !r_rw) r_ovr_err <= 1'b1;
            end else begin
                r_clr_idx <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_char <= 8'h00;
        else     r_rd_char <= r_image[rd_idx];
    end

    always_comb begin
        busy    = (r_state == ST_CLEAR);
        cmd_stb = (r_state == ST_EXEC) && !r_rw && !r_rs;
        chr_stb = (r_state == ST_EXEC) && !r_rw && r_rs;
        dout_oe = en && rw;
        dout    = dout_oe ? {busy, r_addr} : 8'h00;
    end

    assign rd_char   = r_rd_char;
    assign addr      = r_addr;
    assign disp_on   = r_disp_on;
    assign cursor_on = r_cursor_on;
    assign blink_on  = r_blink_on;
    assign inc_mode  = r_inc_mode;
    assign two_line  = r_two_line;
    assign ovr_err   = r_ovr_err;

endmodule
`default_nettype wire
